fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly downstream of pc_register and feeds the IF/ID boundary of the pipelined 16-bit core.
- Issues the current PC to a variable-latency instruction memory and captures the returned word.
- Returns the word to pc_register so that pc_register can compute the next PC, and holds pc_register while a fetch is outstanding.
- Latches the IF/ID register (instruction, pc_plus_two, valid), honours stall/flush from hazard control, and stops fetching after an HLT.

Parameters:
- HLT_OPCODE, 4'hF, opcode that halts fetch.
- BUBBLE_INSTR, 16'h0000, instruction value driven into IF/ID when the slot is invalid (ADD R0,R0,R0).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc  input  16  current PC from pc_register.
- pc_plus_two  input  16  pc + 2 from pc_register.
- stall  input  1  hazard unit: hold the IF/ID register, do not deliver a new word.
- flush  input  1  branch taken downstream: kill IF/ID and any in-flight fetch.
- imem_req  output  1  one-cycle request pulse to instruction memory.
- imem_addr  output  16  fetch address, equals pc while imem_req is high.
- imem_data  input  16  returned instruction word.
- imem_valid  input  1  imem_data is valid this cycle; minimum 1 cycle after imem_req.
- fetch_instruction  output  16  word being delivered this cycle (to pc_register); BUBBLE_INSTR otherwise.
- pc_hold  output  1  1 means pc_register must not update.
- if_id_instruction  output  16  registered IF/ID instruction.
- if_id_pc_plus_two  output  16  registered IF/ID pc+2.
- if_id_valid  output  1  IF/ID slot holds a real instruction.
- halted  output  1  fetch stopped on HLT.

Behaviour:
- Reset (async, rst_n=0) puts the FSM in REQ and drives outputs as follows:
  - if_id_instruction=BUBBLE_INSTR, if_id_pc_plus_two=0, if_id_valid=0.
  - halted=0, imem_req=0, pc_hold=1.
- Reset asserted mid-fetch abandons the request. A late imem_valid arriving while in REQ is ignored.
- FSM states and transitions:
  - REQ: imem_req=1, imem_addr=pc, then go to WAIT. If flush is high in this cycle, go to DRAIN instead.
  - WAIT: imem_req=0. On imem_valid the word is "delivered" if stall=0 and flush=0, "buffered" if stall=1, and "discarded" if flush=1.
  - HOLD: the word is held in an internal 16-bit buffer while stall=1. When stall=0, deliver the buffered word.
  - DRAIN: wait for imem_valid, discard the word, then go to REQ.
  - HALT: no requests are issued, pc_hold=1, halted=1.
- Deliver cycle:
  - Combinational outputs: fetch_instruction = word, pc_hold=0 (pc_register advances on this edge).
  - At the clock edge: if_id_instruction <= word, if_id_pc_plus_two <= pc_plus_two, if_id_valid <= 1.
  - Next state is HALT if word[15:12]==HLT_OPCODE, otherwise REQ.
  - Because pc_register decodes the HLT, its PC does not move on an HLT.
- pc_hold=1 in every cycle that is not a deliver cycle, so exactly one PC update happens per delivered word.
- Stall with no deliver: the IF/ID register keeps its value.
- Flush:
  - Flush has priority over stall and over imem_valid.
  - At the clock edge, if_id_valid <= 0 and if_id_instruction <= BUBBLE_INSTR.
  - Any buffered word is dropped.
  - From HOLD or HALT, go to REQ. From WAIT with imem_valid=1, go to REQ. From WAIT with imem_valid=0, go to DRAIN.
  - halted clears.
- No deliver and no flush: if_id_valid is unchanged.
- imem_valid outside WAIT or DRAIN is ignored.
- Wrap-around: 16'hFFFE + 2 wraps to 16'h0000. No special handling is required; pc_plus_two is passed through unchanged.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_wait_cycles [15:0], reset to 0.
  - It increments in every cycle where the state is WAIT, DRAIN, or HOLD.
  - It saturates at 16'hFFFF.
- Undefined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
- Reset, then memory latency 1, pc=0, imem_data=16'h1234 -> imem_req pulses and imem_addr=0. In the next cycle pc_hold=0 and fetch_instruction=1234. After that edge, if_id_instruction=1234, if_id_pc_plus_two=0002, if_id_valid=1.
- Memory latency 4, three back-to-back fetches -> one deliver every 5 cycles. pc_hold is low for exactly one cycle per word.
- Word 16'h5A5A returned while stall=1 for 3 cycles -> IF/ID unchanged and pc_hold=1 throughout. Delivered on the first cycle with stall=0. No extra imem_req is issued.
- flush asserted in the REQ cycle, latency 3 -> the returned word is discarded and if_id_valid=0. A new request is issued at the redirected pc, e.g. 0x0040.
- Return 16'hF000 -> delivered, if_id_valid=1, halted=1. The next 50 cycles have no imem_req and pc_hold=1. A flush returns the FSM to REQ with halted=0.
- Reset asserted in WAIT, then a late imem_valid arrives -> the word is ignored, all outputs are at reset values, and the post-reset REQ fetches pc=0.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Issues the current PC to a
//            variable-latency instruction memory, hands the returned word back
//            to pc_register (holding it while a fetch is outstanding), latches
//            the IF/ID register, honours stall/flush and stops after an HLT.
// Ports    : clk, rst_n (async, active-low)
//            pc, pc_plus_two            - from pc_register
//            stall, flush               - from hazard control
//            imem_req, imem_addr        - request to instruction memory
//            imem_data, imem_valid      - response from instruction memory
//            fetch_instruction, pc_hold - back to pc_register
//            if_id_instruction, if_id_pc_plus_two, if_id_valid - IF/ID register
//            halted                     - fetch stopped on HLT
//            fetch_wait_cycles          - only with FETCH_PERF_CNT_EN defined
// Options  : FETCH_PERF_CNT_EN - adds a saturating count of cycles spent in
//            WAIT, DRAIN or HOLD.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [3:0]  HLT_OPCODE   = 4'hF,
    parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic [15:0] pc_plus_two,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_valid,
    output logic [15:0] fetch_instruction,
    output logic        pc_hold,
    output logic [15:0] if_id_instruction,
    output logic [15:0] if_id_pc_plus_two,
    output logic        if_id_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] fetch_wait_cycles,
`endif
    output logic        halted
);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_buf;
    logic        w_deliver;
    logic        w_buffer;
    logic [15:0] w_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus the deliver/buffer decisions. Flush is checked before
    // stall and imem_valid so that it always wins.
    always_comb begin
        w_next_state = r_state;
        w_deliver    = 1'b0;
        w_buffer     = 1'b0;
        w_word       = r_buf;
        case (r_state)
            S_REQ: begin
                // The request has already gone out, so a flush here must
                // still absorb the response in DRAIN.
                w_next_state = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    w_next_state = imem_valid ? S_REQ : S_DRAIN;
                end else if (imem_valid) begin
                    if (stall) begin
                        w_buffer     = 1'b1;
                        w_next_state = S_HOLD;
                    end else begin
                        w_deliver = 1'b1;
                        w_word    = imem_data;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_next_state = S_REQ;
                end else if (!stall) begin
                    w_deliver = 1'b1;
                    w_word    = r_buf;
                end
            end
            S_DRAIN: begin
                if (imem_valid) begin
                    w_next_state = S_REQ;
                end
            end
            S_HALT: begin
                if (flush) begin
                    w_next_state = S_REQ;
                end
            end
            default: begin
                w_next_state = S_REQ;
            end
        endcase
        if (w_deliver) begin
            w_next_state = (w_word[15:12] == HLT_OPCODE) ? S_HALT : S_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= 16'h0000;
        end else if (w_buffer) begin
            r_buf <= imem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instruction <= BUBBLE_INSTR;
            if_id_pc_plus_two <= 16'h0000;
            if_id_valid       <= 1'b0;
        end else if (flush) begin
            if_id_instruction <= BUBBLE_INSTR;
            if_id_valid       <= 1'b0;
        end else if (w_deliver) begin
            if_id_instruction <= w_word;
            if_id_pc_plus_two <= pc_plus_two;
            if_id_valid       <= 1'b1;
        end
    end

    // The state register resets to REQ, so the request is masked while reset
    // is held to keep imem_req low during reset.
    assign imem_req          = (r_state == S_REQ) && rst_n;
    assign imem_addr         = pc;
    assign fetch_instruction = w_deliver ? w_word : BUBBLE_INSTR;
    assign pc_hold           = !w_deliver;
    assign halted            = (r_state == S_HALT);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_wait_cycles <= 16'h0000;
        end else if (((r_state == S_WAIT) || (r_state == S_DRAIN) || (r_state == S_HOLD))
                     && (fetch_wait_cycles != 16'hFFFF)) begin
            fetch_wait_cycles <= fetch_wait_cycles + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
